// File: rtl/spatial_encoder_accumulator.sv
// Spatial encoder/accumulator: binds channel hypervectors with projection vectors,
// accumulates per-bit votes over a frame of channel beats and emits the majority vector.
module spatial_encoder_accumulator #(
   parameter int unsigned DIM          = 2048,
   parameter int unsigned NUM_CHANNELS = 4,
   parameter int unsigned FEAT_WIDTH   = 2,
   parameter int unsigned TIE_BREAK    = 1,
   parameter int unsigned CNT_WIDTH    = $clog2(NUM_CHANNELS + 2),
   parameter int unsigned THRESH       = (NUM_CHANNELS + TIE_BREAK) / 2
) (
   input  logic                  Clk_CI,
   input  logic                  Reset_RI,
   input  logic                  Clear_SI,
   input  logic                  InValid_SI,
   output logic                  InReady_SO,
   input  logic [0:DIM-1]        HypervectorIn_DI,
   input  logic [FEAT_WIDTH-1:0] FeatureIn_DI,
   input  logic [0:DIM-1]        ProjPos_DI,
   input  logic [0:DIM-1]        ProjNeg_DI,
   output logic                  OutValid_SO,
   input  logic                  OutReady_SI,
   output logic [0:DIM-1]        HypervectorOut_DO,
   output logic [CNT_WIDTH-1:0]  ChanCount_DO
);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   localparam int unsigned   SW      = CNT_WIDTH + 2;
   localparam logic [SW-1:0] CntMax  = SW'((1 << CNT_WIDTH) - 1);
   localparam logic [SW-1:0] ThreshW = SW'(THRESH);

   state_t                state_q, state_d;
   logic                  in_ready, accept, first_beat, last_beat;
   logic [0:DIM-1]        bound, second_q, majority, hv_out_q;
   logic [CNT_WIDTH-1:0]  cnt_q [DIM];
   logic [CNT_WIDTH-1:0]  cnt_d [DIM];
   logic [CNT_WIDTH-1:0]  chan_q;
   logic                  out_valid_q;

   assign accept     = InValid_SI & in_ready;
   assign first_beat = (chan_q == '0);
   assign last_beat  = (chan_q == CNT_WIDTH'(NUM_CHANNELS - 1));

   always_comb begin
      bound = '0;
      if (FeatureIn_DI == FEAT_WIDTH'(1))
         bound = ProjPos_DI ^ HypervectorIn_DI;
      else if (FeatureIn_DI == FEAT_WIDTH'(2))
         bound = ProjNeg_DI ^ HypervectorIn_DI;
   end

   // First beat overwrites the counter; the last beat adds the optional tie vote.
   always_comb begin
      majority = '0;
      for (int unsigned i = 0; i < DIM; i++) begin
         automatic logic [SW-1:0] sum;
         sum = first_beat ? '0 : {2'b00, cnt_q[i]};
         sum = sum + {{(SW-1){1'b0}}, bound[i]};
         if (last_beat && (TIE_BREAK != 0))
            sum = sum + {{(SW-1){1'b0}}, second_q[i] ^ bound[i]};
         if (sum > CntMax)
            sum = CntMax;
         cnt_d[i]    = sum[CNT_WIDTH-1:0];
         majority[i] = (sum > ThreshW);
      end
   end

   always_ff @(posedge Clk_CI or posedge Reset_RI) begin
      if (Reset_RI)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      in_ready = (state_q != HOLD);
      case (state_q)
         IDLE:    if (accept) state_d = last_beat ? HOLD : ACCUM;
         ACCUM:   if (accept && last_beat) state_d = HOLD;
         HOLD:    if (OutReady_SI) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (Clear_SI)
         state_d = IDLE;
   end

   always_ff @(posedge Clk_CI or posedge Reset_RI) begin
      if (Reset_RI) begin
         cnt_q       <= '{default: '0};
         second_q    <= '0;
         hv_out_q    <= '0;
         chan_q      <= '0;
         out_valid_q <= 1'b0;
      end else if (Clear_SI) begin
         cnt_q       <= '{default: '0};
         chan_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            cnt_q <= cnt_d;
            if ((chan_q == CNT_WIDTH'(1)) && (TIE_BREAK != 0))
               second_q <= bound;
            if (last_beat) begin
               hv_out_q    <= majority;
               out_valid_q <= 1'b1;
               chan_q      <= '0;
            end else begin
               chan_q <= chan_q + CNT_WIDTH'(1);
            end
         end
         if ((state_q == HOLD) && OutReady_SI)
            out_valid_q <= 1'b0;
      end
   end

   assign InReady_SO        = in_ready;
   assign OutValid_SO       = out_valid_q;
   assign HypervectorOut_DO = hv_out_q;
   assign ChanCount_DO      = chan_q;

endmodule

// File: tb/tb_spatial_encoder_accumulator.sv
// Directed bench: a 3-channel no-tie instance and a 4-channel tie-break instance, both DIM=8.
module tb_spatial_encoder_accumulator;

   logic       clk = 1'b0;
   logic       rst, clr;
   logic [0:7] hv, pos, neg;
   logic [1:0] feat;
   logic       v3, r3, v4, r4;
   logic       ir3, ov3, ir4, ov4;
   logic [0:7] out3, out4;
   logic [2:0] cc3, cc4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   spatial_encoder_accumulator #(.DIM(8), .NUM_CHANNELS(3), .FEAT_WIDTH(2), .TIE_BREAK(0)) u3 (
      .Clk_CI(clk), .Reset_RI(rst), .Clear_SI(clr), .InValid_SI(v3), .InReady_SO(ir3),
      .HypervectorIn_DI(hv), .FeatureIn_DI(feat), .ProjPos_DI(pos), .ProjNeg_DI(neg),
      .OutValid_SO(ov3), .OutReady_SI(r3), .HypervectorOut_DO(out3), .ChanCount_DO(cc3));

   spatial_encoder_accumulator #(.DIM(8), .NUM_CHANNELS(4), .FEAT_WIDTH(2), .TIE_BREAK(1)) u4 (
      .Clk_CI(clk), .Reset_RI(rst), .Clear_SI(clr), .InValid_SI(v4), .InReady_SO(ir4),
      .HypervectorIn_DI(hv), .FeatureIn_DI(feat), .ProjPos_DI(pos), .ProjNeg_DI(neg),
      .OutValid_SO(ov4), .OutReady_SI(r4), .HypervectorOut_DO(out4), .ChanCount_DO(cc4));

   typedef struct {
      string      name;
      bit         sel;   // 0 = u3, 1 = u4
      logic       vld;
      logic       rdy;
      logic [1:0] feat;
      logic [7:0] hv;
      logic [7:0] pos;
      logic [7:0] neg;
      logic       e_ov;
      logic [7:0] e_out;
      logic [2:0] e_cc;
      logic       e_ir;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive3(input logic vld, input logic rdy, input logic [1:0] f,
                         input logic [7:0] h, input logic [7:0] p);
      v3 = vld; r3 = rdy; feat = f; hv = h; pos = p; neg = 8'h00;
      step();
   endtask

   task automatic chk3(input string tag, input logic e_ov, input logic [7:0] e_out,
                       input logic [2:0] e_cc, input logic e_ir);
      chk({tag, ".ov"}, 32'(ov3), 32'(e_ov));
      chk({tag, ".out"}, 32'(out3), 32'(e_out));
      chk({tag, ".cc"}, 32'(cc3), 32'(e_cc));
      chk({tag, ".ir"}, 32'(ir3), 32'(e_ir));
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; v3 = 1'b0; v4 = 1'b0; r3 = 1'b1; r4 = 1'b1;
      hv = '0; pos = '0; neg = '0; feat = '0;

      // T1: bound FF,00,F0 -> F0
      vecs.push_back('{"t1b1", 0, 1, 1, 2'd1, 8'h00, 8'hFF, 8'h00, 0, 8'h00, 3'd1, 1});
      vecs.push_back('{"t1b2", 0, 1, 1, 2'd1, 8'hFF, 8'hFF, 8'h00, 0, 8'h00, 3'd2, 1});
      vecs.push_back('{"t1b3", 0, 1, 1, 2'd1, 8'h0F, 8'hFF, 8'h00, 1, 8'hF0, 3'd0, 0});
      vecs.push_back('{"t1rel", 0, 0, 1, 2'd1, 8'h00, 8'hFF, 8'h00, 0, 8'hF0, 3'd0, 1});
      // T2: no-vote features -> 00
      vecs.push_back('{"t2b1", 0, 1, 1, 2'd0, 8'hAA, 8'hFF, 8'h00, 0, 8'hF0, 3'd1, 1});
      vecs.push_back('{"t2b2", 0, 1, 1, 2'd3, 8'hAA, 8'hFF, 8'h00, 0, 8'hF0, 3'd2, 1});
      vecs.push_back('{"t2b3", 0, 1, 1, 2'd0, 8'h55, 8'hFF, 8'h00, 1, 8'h00, 3'd0, 0});
      vecs.push_back('{"t2rel", 0, 0, 1, 2'd0, 8'h00, 8'hFF, 8'h00, 0, 8'h00, 3'd0, 1});
      // T3: bound FF,0F,00,0F; tie = 0F^0F = 0 -> 0F
      vecs.push_back('{"t3b1", 1, 1, 1, 2'd1, 8'h00, 8'hFF, 8'h00, 0, 8'h00, 3'd1, 1});
      vecs.push_back('{"t3b2", 1, 1, 1, 2'd2, 8'h00, 8'h00, 8'h0F, 0, 8'h00, 3'd2, 1});
      vecs.push_back('{"t3b3", 1, 1, 1, 2'd1, 8'hFF, 8'hFF, 8'h00, 0, 8'h00, 3'd3, 1});
      vecs.push_back('{"t3b4", 1, 1, 1, 2'd1, 8'hFF, 8'hF0, 8'h00, 1, 8'h0F, 3'd0, 0});
      vecs.push_back('{"t3rel", 1, 0, 1, 2'd1, 8'h00, 8'hFF, 8'h00, 0, 8'h0F, 3'd0, 1});
      // Tie vote decides: bound FF,F0,00,0F; tie F0^0F = FF -> every bit 3 votes -> FF
      vecs.push_back('{"tbb1", 1, 1, 1, 2'd1, 8'h00, 8'hFF, 8'h00, 0, 8'h0F, 3'd1, 1});
      vecs.push_back('{"tbb2", 1, 1, 1, 2'd1, 8'h0F, 8'hFF, 8'h00, 0, 8'h0F, 3'd2, 1});
      vecs.push_back('{"tbb3", 1, 1, 1, 2'd3, 8'h0F, 8'hFF, 8'h00, 0, 8'h0F, 3'd3, 1});
      vecs.push_back('{"tbb4", 1, 1, 1, 2'd2, 8'hFF, 8'h00, 8'hF0, 1, 8'hFF, 3'd0, 0});
      vecs.push_back('{"tbrel", 1, 0, 1, 2'd0, 8'h00, 8'h00, 8'h00, 0, 8'hFF, 3'd0, 1});

      #12;
      chk("rst.ov3", 32'(ov3), 32'd0);
      chk("rst.out3", 32'(out3), 32'd0);
      chk("rst.cc3", 32'(cc3), 32'd0);
      chk("rst.ir3", 32'(ir3), 32'd1);
      chk("rst.ov4", 32'(ov4), 32'd0);
      chk("rst.cc4", 32'(cc4), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         feat = vecs[i].feat; hv = vecs[i].hv; pos = vecs[i].pos; neg = vecs[i].neg;
         if (vecs[i].sel == 1'b0) begin
            v3 = vecs[i].vld; r3 = vecs[i].rdy; v4 = 1'b0; r4 = 1'b1;
         end else begin
            v4 = vecs[i].vld; r4 = vecs[i].rdy; v3 = 1'b0; r3 = 1'b1;
         end
         step();
         if (vecs[i].sel == 1'b0) begin
            chk({vecs[i].name, ".ov"}, 32'(ov3), 32'(vecs[i].e_ov));
            chk({vecs[i].name, ".out"}, 32'(out3), 32'(vecs[i].e_out));
            chk({vecs[i].name, ".cc"}, 32'(cc3), 32'(vecs[i].e_cc));
            chk({vecs[i].name, ".ir"}, 32'(ir3), 32'(vecs[i].e_ir));
         end else begin
            chk({vecs[i].name, ".ov"}, 32'(ov4), 32'(vecs[i].e_ov));
            chk({vecs[i].name, ".out"}, 32'(out4), 32'(vecs[i].e_out));
            chk({vecs[i].name, ".cc"}, 32'(cc4), 32'(vecs[i].e_cc));
            chk({vecs[i].name, ".ir"}, 32'(ir4), 32'(vecs[i].e_ir));
         end
      end
      v4 = 1'b0; r4 = 1'b1;

      // T4: back-pressure with InValid_SI held high
      drive3(1, 0, 2'd1, 8'h00, 8'hFF);
      drive3(1, 0, 2'd1, 8'hFF, 8'hFF);
      drive3(1, 0, 2'd1, 8'h0F, 8'hFF);
      chk3("t4last", 1, 8'hF0, 3'd0, 0);
      for (int c = 0; c < 5; c++) begin
         drive3(1, 0, 2'd1, 8'h33, 8'hFF);
         chk3($sformatf("t4hold%0d", c), 1, 8'hF0, 3'd0, 0);
      end
      drive3(1, 1, 2'd1, 8'h33, 8'hFF);
      chk3("t4rel", 0, 8'hF0, 3'd0, 1);
      drive3(1, 1, 2'd1, 8'h33, 8'hFF);
      chk3("t4next", 0, 8'hF0, 3'd1, 1);
      v3 = 1'b0; clr = 1'b1;
      step();
      clr = 1'b0;
      chk3("t4clr", 0, 8'hF0, 3'd0, 1);

      // T5: async reset mid-cycle after two beats
      drive3(1, 1, 2'd1, 8'h00, 8'hFF);
      drive3(1, 1, 2'd1, 8'hFF, 8'hFF);
      chk3("t5pre", 0, 8'hF0, 3'd2, 1);
      v3 = 1'b0;
      #2 rst = 1'b1;
      #1 chk3("t5rst", 0, 8'h00, 3'd0, 1);
      #1 rst = 1'b0;
      drive3(1, 1, 2'd1, 8'h00, 8'hFF);
      drive3(1, 1, 2'd1, 8'hFF, 8'hFF);
      drive3(1, 1, 2'd1, 8'h0F, 8'hFF);
      chk3("t5res", 1, 8'hF0, 3'd0, 0);
      drive3(0, 1, 2'd1, 8'h00, 8'hFF);
      chk3("t5rel", 0, 8'hF0, 3'd0, 1);

      // T6: Clear_SI coincides with the last-beat accept
      drive3(1, 1, 2'd1, 8'hFF, 8'hFF);
      drive3(1, 1, 2'd1, 8'hFF, 8'hFF);
      clr = 1'b1;
      drive3(1, 1, 2'd1, 8'hFF, 8'hFF);
      clr = 1'b0;
      chk3("t6clr", 0, 8'hF0, 3'd0, 1);
      drive3(0, 1, 2'd1, 8'h00, 8'hFF);
      chk3("t6idle", 0, 8'hF0, 3'd0, 1);
      // bound FF,0F,00 -> upper 1 vote, lower 2 votes -> 0F
      drive3(1, 1, 2'd1, 8'h00, 8'hFF);
      drive3(1, 1, 2'd1, 8'hF0, 8'hFF);
      drive3(1, 1, 2'd1, 8'hFF, 8'hFF);
      chk3("t6res", 1, 8'h0F, 3'd0, 0);
      drive3(0, 1, 2'd1, 8'h00, 8'hFF);
      chk3("t6rel", 0, 8'h0F, 3'd0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
